// File: rtl/morse_symbol_assembler.sv
// Morse element assembler: debounces the dot/dash toggle switches, collects up to
// MAX_LEN symbols per element and hands each closed element downstream over valid/ready.
module morse_symbol_assembler #(
    parameter int MAX_LEN         = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 50_000_000,
    localparam int LEN_W          = $clog2(MAX_LEN + 1),
    localparam int GAP_W          = $clog2(GAP_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         sw,
    input  logic               commit,
    output logic [MAX_LEN-1:0] morse_code,
    output logic [LEN_W-1:0]   morse_len,
    output logic               morse_valid,
    input  logic               morse_ready,
    output logic               overflow,
    output logic               busy
);

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LEN_W-1:0]   FULL_LEN = LEN_W'(MAX_LEN);
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_MAX  = GAP_W'(GAP_CYCLES);
    localparam logic [MAX_LEN-1:0] TOP_BIT  = {1'b1, {(MAX_LEN-1){1'b0}}};

    // Input synchroniser and debounce state
    logic [1:0]            sw_p0;
    logic [1:0]            sw_p1;
    logic [1:0]            level;
    logic                  prime;
    logic [1:0][CNT_W-1:0] db_cnt;
    logic [1:0]            evt;

    // Assembly buffer and close control
    logic [MAX_LEN-1:0]    asm_code;
    logic [LEN_W-1:0]      asm_len;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  pending;

    logic [MAX_LEN-1:0]    code_app;
    logic [LEN_W-1:0]      len_app;
    logic                  appended;
    logic                  dropped;
    logic                  gap_hit;
    logic                  close_req;
    logic                  out_free;
    logic                  transfer;

    logic [MAX_LEN-1:0]    asm_code_nx;
    logic [LEN_W-1:0]      asm_len_nx;
    logic [GAP_W-1:0]      gap_cnt_nx;
    logic                  pending_nx;
    logic [MAX_LEN-1:0]    out_code_nx;
    logic [LEN_W-1:0]      out_len_nx;
    logic                  out_valid_nx;

    function automatic logic [GAP_W-1:0] gap_step(input logic [GAP_W-1:0] cnt);
        return (cnt == GAP_MAX) ? cnt : cnt + 1'b1;
    endfunction

    // Stage p0/p1: two-flop synchroniser, no reset needed on pure data
    always_ff @(posedge clk) begin
        sw_p0 <= sw;
        sw_p1 <= sw_p0;
    end

    // Debounce: the first cycle out of reset adopts the current levels silently
    always_ff @(posedge clk) begin
        if (reset) begin
            level  <= '0;
            prime  <= 1'b1;
            db_cnt <= '0;
            evt    <= '0;
        end else if (prime) begin
            level  <= sw_p1;
            prime  <= 1'b0;
            db_cnt <= '0;
            evt    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                evt[i] <= 1'b0;
                if (sw_p1[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= ~level[i];
                    evt[i]    <= 1'b1;
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next-state: append events (dot before dash), then decide on a close/transfer
    always_comb begin
        code_app = asm_code;
        len_app  = asm_len;
        appended = 1'b0;
        dropped  = 1'b0;

        if (evt[0]) begin
            if (len_app == FULL_LEN) begin
                dropped = 1'b1;
            end else begin
                len_app  = len_app + 1'b1;
                appended = 1'b1;
            end
        end
        if (evt[1]) begin
            if (len_app == FULL_LEN) begin
                dropped = 1'b1;
            end else begin
                code_app = code_app | (TOP_BIT >> len_app);
                len_app  = len_app + 1'b1;
                appended = 1'b1;
            end
        end

        // Full and gap closes look at the pre-append buffer; commit takes the post-append one
        gap_hit   = (asm_len != '0) && (gap_cnt >= GAP_LAST);
        close_req = (len_app != '0) &&
                    ((asm_len == FULL_LEN) || gap_hit || commit || pending);
        out_free  = !morse_valid || morse_ready;
        transfer  = close_req && out_free;

        asm_code_nx  = code_app;
        asm_len_nx   = len_app;
        pending_nx   = pending || (close_req && (commit || gap_hit));
        gap_cnt_nx   = appended ? '0 : ((asm_len != '0) ? gap_step(gap_cnt) : gap_cnt);
        out_code_nx  = morse_code;
        out_len_nx   = morse_len;
        out_valid_nx = morse_valid && !morse_ready;

        if (transfer) begin
            asm_code_nx  = '0;
            asm_len_nx   = '0;
            pending_nx   = 1'b0;
            gap_cnt_nx   = '0;
            out_code_nx  = code_app;
            out_len_nx   = len_app;
            out_valid_nx = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_code    <= '0;
            asm_len     <= '0;
            gap_cnt     <= '0;
            pending     <= 1'b0;
            morse_code  <= '0;
            morse_len   <= '0;
            morse_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            asm_code    <= asm_code_nx;
            asm_len     <= asm_len_nx;
            gap_cnt     <= gap_cnt_nx;
            pending     <= pending_nx;
            morse_code  <= out_code_nx;
            morse_len   <= out_len_nx;
            morse_valid <= out_valid_nx;
            overflow    <= dropped;
        end
    end

    always_comb begin
        busy = (asm_len != '0) || pending;
    end

endmodule

// File: tb/tb_morse_symbol_assembler.sv
// Bench for morse_symbol_assembler: directed element table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_morse_symbol_assembler;

    localparam int MAX_LEN = 5;
    localparam int DB      = 2;
    localparam int GAP     = 20;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int N_RND   = 3000;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         sw;
    logic               commit;
    logic [MAX_LEN-1:0] morse_code;
    logic [LEN_W-1:0]   morse_len;
    logic               morse_valid;
    logic               morse_ready;
    logic               overflow;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    morse_symbol_assembler #(
        .MAX_LEN(MAX_LEN),
        .DEBOUNCE_CYCLES(DB),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .commit(commit),
        .morse_code(morse_code),
        .morse_len(morse_len),
        .morse_valid(morse_valid),
        .morse_ready(morse_ready),
        .overflow(overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // mode: 0 = gap close, 1 = commit close, 2 = full close
    typedef struct {
        int       nsym;
        logic [4:0] syms;
        int       mode;
        logic [4:0] exp_code;
        int       exp_len;
        int       exp_lat;
    } vec_t;

    vec_t vecs[5];

    // Reference model state
    bit q[$];
    int m_valid, m_code, m_len, m_ovf, m_pend, last_app;
    bit ev_dot[64];
    bit ev_dash[64];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        int first, nv, hold_bad, ovf_cnt, b, busy_seen, valid_seen;
        int len_pre, hit, app, drop, close, free, code;
        int lt[2];
        bit dot, dash;

        vecs[0] = '{3, 5'b01000, 0, 5'b01000, 3, 3 + DB + GAP};
        vecs[1] = '{5, 5'b10101, 2, 5'b10101, 5, 4 + DB};
        vecs[2] = '{2, 5'b11000, 1, 5'b11000, 2, 9};
        vecs[3] = '{1, 5'b10000, 0, 5'b10000, 1, 3 + DB + GAP};
        vecs[4] = '{4, 5'b01100, 1, 5'b01100, 4, 9};

        reset = 1'b1; sw = 2'b00; commit = 1'b0; morse_ready = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("reset_valid", morse_valid, 0);
        check("reset_code", morse_code, 0);
        check("reset_len", morse_len, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);

        // Table-driven elements
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < vecs[v].nsym; k++) begin
                b = vecs[v].syms[4-k] ? 1 : 0;
                sw[b] = ~sw[b];
                if (k != vecs[v].nsym - 1) repeat (10) tick();
            end
            first = -1; nv = 0;
            for (int t = 1; t <= 40; t++) begin
                tick();
                if (morse_valid) begin
                    if (first < 0) begin
                        first = t;
                        check($sformatf("vec%0d_code", v), morse_code, vecs[v].exp_code);
                        check($sformatf("vec%0d_len", v), morse_len, vecs[v].exp_len);
                        check($sformatf("vec%0d_busy", v), busy, 0);
                    end
                    nv++;
                end
                commit = (vecs[v].mode == 1 && t == 8);
            end
            commit = 1'b0;
            check($sformatf("vec%0d_latency", v), first, vecs[v].exp_lat);
            check($sformatf("vec%0d_valid_cycles", v), nv, 1);
        end

        // Bounce: three one-cycle glitches, then a stable toggle
        repeat (3) begin
            sw[0] = ~sw[0];
            tick();
            sw[0] = ~sw[0];
            repeat (6) tick();
        end
        check("bounce_no_symbol", busy, 0);
        sw[0] = ~sw[0];
        repeat (8) tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("bounce_valid", morse_valid, 1);
        check("bounce_len", morse_len, 1);
        check("bounce_code", morse_code, 0);
        repeat (5) tick();

        // Simultaneous dot+dash with commit in the event cycle
        sw = ~sw;
        repeat (2 + DB) tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("simul_valid", morse_valid, 1);
        check("simul_code", morse_code, 5'b01000);
        check("simul_len", morse_len, 2);
        check("simul_busy", busy, 0);
        repeat (5) tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        valid_seen = 0;
        for (int t = 0; t < 6; t++) begin
            if (morse_valid) valid_seen++;
            tick();
        end
        check("empty_commit_valid", valid_seen, 0);
        check("empty_commit_busy", busy, 0);

        // Backpressure: one element held, the buffer fills and overflows
        morse_ready = 1'b0;
        sw[0] = ~sw[0];
        repeat (10) tick();
        sw[1] = ~sw[1];
        repeat (10) tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("bp_first_valid", morse_valid, 1);
        check("bp_first_code", morse_code, 5'b01000);
        hold_bad = 0; ovf_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            b = k % 2;
            sw[b] = ~sw[b];
            repeat (10) begin
                tick();
                if (!(morse_valid && morse_code == 5'b01000 && morse_len == 2)) hold_bad++;
                if (overflow) ovf_cnt++;
            end
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("bp_hold_stable", hold_bad, 0);
        check("bp_overflow_pulses", ovf_cnt, 1);
        check("bp_busy_full", busy, 1);
        morse_ready = 1'b1;
        tick();
        check("bp_second_valid", morse_valid, 1);
        check("bp_second_code", morse_code, 5'b01010);
        check("bp_second_len", morse_len, 5);
        tick();
        check("bp_drain_valid", morse_valid, 0);
        check("bp_drain_busy", busy, 0);

        // Reset mid-element with both switches high
        sw = 2'b10;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        sw[0] = ~sw[0];
        repeat (10) tick();
        sw[1] = ~sw[1];
        repeat (10) tick();
        sw[1] = ~sw[1];
        repeat (6) tick();
        check("mid_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", morse_valid, 0);
        check("mid_rst_code", morse_code, 0);
        check("mid_rst_len", morse_len, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_busy", busy, 0);
        busy_seen = 0; valid_seen = 0;
        repeat (20) begin
            tick();
            if (busy) busy_seen++;
            if (morse_valid) valid_seen++;
        end
        check("mid_no_events", busy_seen, 0);
        check("mid_no_output", valid_seen, 0);
        sw[1] = ~sw[1];
        repeat (8) tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("mid_next_valid", morse_valid, 1);
        check("mid_next_code", morse_code, 5'b10000);
        check("mid_next_len", morse_len, 1);

        // Randomized run against the reference model
        sw = 2'b00;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        q.delete();
        m_valid = 0; m_code = 0; m_len = 0; m_ovf = 0; m_pend = 0; last_app = -1000;
        for (int i = 0; i < 64; i++) begin
            ev_dot[i] = 1'b0;
            ev_dash[i] = 1'b0;
        end
        lt[0] = -100; lt[1] = -100;
        for (int j = 0; j < N_RND; j++) begin
            tick();
            check("rnd_valid", morse_valid, m_valid);
            check("rnd_overflow", overflow, m_ovf);
            check("rnd_busy", busy, (q.size() > 0 || m_pend) ? 1 : 0);
            if (m_valid) begin
                check("rnd_code", morse_code, m_code);
                check("rnd_len", morse_len, m_len);
            end

            morse_ready = ($urandom_range(3) != 0);
            commit = ($urandom_range(39) == 0);
            for (int bb = 0; bb < 2; bb++) begin
                if (j - lt[bb] >= 8 && $urandom_range(5) == 0) begin
                    sw[bb] = ~sw[bb];
                    lt[bb] = j;
                    if (bb == 0) ev_dot[(j + 2 + DB) % 64] = 1'b1;
                    else         ev_dash[(j + 2 + DB) % 64] = 1'b1;
                end
            end

            // Model: the edge that ends this cycle is edge j+1
            dot = ev_dot[j % 64];
            dash = ev_dash[j % 64];
            ev_dot[j % 64] = 1'b0;
            ev_dash[j % 64] = 1'b0;
            len_pre = q.size();
            hit = (len_pre > 0 && (j + 1) - last_app >= GAP);
            app = 0; drop = 0;
            if (dot) begin
                if (q.size() < MAX_LEN) begin q.push_back(1'b0); app = 1; end
                else drop = 1;
            end
            if (dash) begin
                if (q.size() < MAX_LEN) begin q.push_back(1'b1); app = 1; end
                else drop = 1;
            end
            if (app) last_app = j + 1;
            close = (q.size() > 0) && (len_pre == MAX_LEN || hit || commit || m_pend);
            free = (!m_valid || morse_ready);
            m_ovf = drop;
            if (close && free) begin
                code = 0;
                for (int i = 0; i < q.size(); i++) if (q[i]) code += (1 << (MAX_LEN - 1 - i));
                m_code = code;
                m_len = q.size();
                m_valid = 1;
                q.delete();
                m_pend = 0;
            end else begin
                if (m_valid && morse_ready) m_valid = 0;
                if (close && (commit || hit)) m_pend = 1;
            end
        end
        commit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
